sca_rd_cntrl: RTL and testbench

SCA readout sequencer: the read side of the SCA block buffer, consuming blocks that the write-side controller has filled and tagged with an LCT. Pops one queued block address, steps through its 16 cells: drives the SCA read address, waits for settle, pulses ADC conversion, strobes the word downstream. Then returns the block to the free pool. Sits between the LCT/block-address FIFO and the ADC/readout FIFO.

---
 rtl/sca_rd_cntrl.sv | 198 +++++++++++++++++++
 tb/tb_sca_rd_cntrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sca_rd_cntrl.sv
// sca_rd_cntrl - SCA readout sequencer.
// Takes one block address from the block FIFO, reads its 16 cells (settle,
// convert, strobe), then returns the block to the free pool.
// Build option: define SCA_RD_ABORT_EN so that ABORT cuts the current block
// short and frees it. Without it, ABORT is ignored.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a queued block and room downstream
// LOAD   | block latched; clear sample index, preload settle count
// SETTLE | SCA read enabled, waiting for the cell output to settle
// CONV   | ADC conversion in progress (start pulse on first cycle)
// STRB   | word valid to readout FIFO; advance to next cell or finish
// WAIT   | readout FIFO almost full; hold before next cell
// FREE   | release block address back to the free pool
module sca_rd_cntrl #(
  parameter int TMR    = 0,
  parameter int SETTLE = 3,
  parameter int CONV   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BLK_VLD,
  input  logic [3:0] BLK_ADDR,
  input  logic       FIFO_AFULL,
  input  logic       ABORT,
  output logic       BLK_RD,
  output logic [7:0] SCA_RADR,
  output logic       SCA_RDENA,
  output logic       ADC_CONV,
  output logic       DATA_STRB,
  output logic       LAST_SMP,
  output logic       BLK_FREE,
  output logic [3:0] FREE_ADDR,
  output logic       BUSY,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_CONV   = 3'd3,
    S_STRB   = 3'd4,
    S_WAIT   = 3'd5,
    S_FREE   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam int NC = (TMR != 0) ? 3 : 1;

  // State and counters, one copy or three voted copies
  logic [2:0] r_st  [NC];
  logic [3:0] r_cnt [NC];
  logic [3:0] r_smp [NC];
  logic [3:0] r_blk [NC];

  logic [2:0] w_st_v;
  logic [3:0] w_cnt;
  logic [3:0] w_smp;
  logic [3:0] w_blk;
  state_t     w_st;

  state_t     w_nst;
  logic [3:0] w_ncnt;
  logic [3:0] w_nsmp;
  logic [3:0] w_nblk;

  logic       r_rdena;
  logic       r_conv;
  logic       r_strb;
  logic       r_last;
  logic       r_free;
  logic [3:0] r_free_addr;
  logic       r_busy;

  generate
    if (TMR != 0) begin : g_tmr
      assign w_st_v = (r_st[0] & r_st[1]) | (r_st[0] & r_st[2]) | (r_st[1] & r_st[2]);
      assign w_cnt  = (r_cnt[0] & r_cnt[1]) | (r_cnt[0] & r_cnt[2]) | (r_cnt[1] & r_cnt[2]);
      assign w_smp  = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
      assign w_blk  = (r_blk[0] & r_blk[1]) | (r_blk[0] & r_blk[2]) | (r_blk[1] & r_blk[2]);
    end else begin : g_single
      assign w_st_v = r_st[0];
      assign w_cnt  = r_cnt[0];
      assign w_smp  = r_smp[0];
      assign w_blk  = r_blk[0];
    end
  endgenerate

  assign w_st = state_t'(w_st_v);

  // Pop is combinational so the block address is taken on the accept edge
  assign BLK_RD = !RST && (w_st == S_IDLE) && BLK_VLD && !FIFO_AFULL;

`ifndef SCA_RD_ABORT_EN
  logic w_unused_abort;
  assign w_unused_abort = ABORT;
`endif

  // Next-state and counter update for the sequencer
  always_comb begin
    w_nst  = w_st;
    w_ncnt = w_cnt;
    w_nsmp = w_smp;
    w_nblk = w_blk;
    case (w_st)
      S_IDLE: begin
        if (BLK_RD) begin
          w_nblk = BLK_ADDR;
          w_nst  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_nsmp = 4'd0;
        w_ncnt = 4'(SETTLE - 1);
        w_nst  = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_cnt == 4'd0) begin
          w_ncnt = 4'(CONV - 1);
          w_nst  = S_CONV;
        end else begin
          w_ncnt = w_cnt - 4'd1;
        end
      end
      S_CONV: begin
        if (w_cnt == 4'd0) w_nst = S_STRB;
        else               w_ncnt = w_cnt - 4'd1;
      end
      S_STRB: begin
        if (w_smp == 4'hF) begin
          w_nst = S_FREE;
        end else begin
          w_nsmp = w_smp + 4'd1;
          w_ncnt = 4'(SETTLE - 1);
          w_nst  = FIFO_AFULL ? S_WAIT : S_SETTLE;
        end
      end
      S_WAIT: begin
        if (!FIFO_AFULL) w_nst = S_SETTLE;
      end
      S_FREE:  w_nst = S_IDLE;
      default: w_nst = S_IDLE;
    endcase
`ifdef SCA_RD_ABORT_EN
    if (ABORT && (w_st inside {S_LOAD, S_SETTLE, S_CONV, S_STRB, S_WAIT})) begin
      w_nst  = S_FREE;
      w_nsmp = w_smp;
      w_ncnt = w_cnt;
    end
`endif
  end

  // Register state copies and decode outputs one cycle ahead so they align with the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NC; i++) begin
        r_st[i]  <= S_IDLE;
        r_cnt[i] <= 4'd0;
        r_smp[i] <= 4'd0;
        r_blk[i] <= 4'd0;
      end
      r_rdena     <= 1'b0;
      r_conv      <= 1'b0;
      r_strb      <= 1'b0;
      r_last      <= 1'b0;
      r_free      <= 1'b0;
      r_free_addr <= 4'd0;
      r_busy      <= 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        r_st[i]  <= w_nst;
        r_cnt[i] <= w_ncnt;
        r_smp[i] <= w_nsmp;
        r_blk[i] <= w_nblk;
      end
      r_rdena     <= (w_nst == S_SETTLE) || (w_nst == S_CONV);
      r_conv      <= (w_nst == S_CONV) && (w_st != S_CONV);
      r_strb      <= (w_nst == S_STRB);
      r_last      <= (w_nst == S_STRB) && (w_nsmp == 4'hF);
      r_free      <= (w_nst == S_FREE);
      r_free_addr <= (w_nst == S_FREE) ? w_nblk : 4'd0;
      r_busy      <= (w_nst != S_IDLE);
    end
  end

  assign SCA_RADR  = {w_blk, w_smp};
  assign SCA_RDENA = r_rdena;
  assign ADC_CONV  = r_conv;
  assign DATA_STRB = r_strb;
  assign LAST_SMP  = r_last;
  assign BLK_FREE  = r_free;
  assign FREE_ADDR = r_free_addr;
  assign BUSY      = r_busy;
  assign STATE     = w_st_v;

endmodule

// File: tb/tb_sca_rd_cntrl.sv
// tb_sca_rd_cntrl - bench for the SCA readout sequencer.
module tb_sca_rd_cntrl;
  localparam int S = 3;
  localparam int C = 4;
  localparam int P = S + C + 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BLK_VLD;
  logic [3:0] BLK_ADDR;
  logic       FIFO_AFULL;
  logic       ABORT;
  logic       BLK_RD;
  logic [7:0] SCA_RADR;
  logic       SCA_RDENA;
  logic       ADC_CONV;
  logic       DATA_STRB;
  logic       LAST_SMP;
  logic       BLK_FREE;
  logic [3:0] FREE_ADDR;
  logic       BUSY;
  logic [2:0] STATE;

  sca_rd_cntrl #(.TMR(0), .SETTLE(S), .CONV(C)) dut (
    .CLK(CLK), .RST(RST), .BLK_VLD(BLK_VLD), .BLK_ADDR(BLK_ADDR),
    .FIFO_AFULL(FIFO_AFULL), .ABORT(ABORT), .BLK_RD(BLK_RD),
    .SCA_RADR(SCA_RADR), .SCA_RDENA(SCA_RDENA), .ADC_CONV(ADC_CONV),
    .DATA_STRB(DATA_STRB), .LAST_SMP(LAST_SMP), .BLK_FREE(BLK_FREE),
    .FREE_ADDR(FREE_ADDR), .BUSY(BUSY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       vld;
    logic       afull;
    logic [3:0] addr;
    logic       e_rd;
    logic [2:0] e_state;
  } vec_t;

  vec_t tbl [4];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_conv = 0;
  int t0;
  int strb_log[$];
  int last_log[$];
  int free_cyc[$];
  int free_log[$];
  int acc_log[$];

  // Reference model: timestamps of the next strobe rather than a state machine
  bit   m_busy;
  bit   m_pend;
  logic [3:0] m_blk;
  int   m_k;
  int   m_next;
  int   m_free_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_blk = 4'd0; m_k = 0; m_next = -1000; m_free_at = -1;
  endtask

  task automatic clr_logs();
    strb_log.delete(); last_log.delete(); free_cyc.delete();
    free_log.delete(); acc_log.delete(); n_conv = 0;
  endtask

  // One clock: compare at negedge against the model, advance model, move past posedge
  task automatic tick();
    logic       e_rd, e_rdena, e_conv, e_strb, e_last, e_free, e_busy, run, ab;
    logic [3:0] e_fa;
    logic [7:0] e_radr, a_radr;
    @(negedge CLK);
    e_rd = 0; e_rdena = 0; e_conv = 0; e_strb = 0; e_last = 0;
    e_free = 0; e_busy = 0; e_fa = 4'd0; e_radr = 8'd0; ab = 0;
    if (RST) begin
      model_reset();
    end else begin
      run     = m_busy && (m_free_at < 0) && !m_pend;
      e_rd    = !m_busy && BLK_VLD && !FIFO_AFULL;
      e_strb  = run && (cyc == m_next);
      e_last  = e_strb && (m_k == 15);
      e_conv  = run && (cyc == m_next - C);
      e_rdena = run && (cyc >= m_next - C - S) && (cyc < m_next);
      e_free  = m_busy && (cyc == m_free_at);
      e_fa    = e_free ? m_blk : 4'd0;
      e_busy  = m_busy;
      e_radr  = e_strb ? {m_blk, 4'(m_k)} : 8'd0;
    end
    a_radr = (RST || DATA_STRB) ? SCA_RADR : 8'd0;
    chk("outputs", {BLK_RD, SCA_RDENA, ADC_CONV, DATA_STRB, LAST_SMP, BLK_FREE, FREE_ADDR, BUSY, a_radr},
                   {e_rd, e_rdena, e_conv, e_strb, e_last, e_free, e_fa, e_busy, e_radr});
    if (!RST) begin
      if (DATA_STRB) strb_log.push_back(cyc);
      if (LAST_SMP)  last_log.push_back(cyc);
      if (ADC_CONV)  n_conv++;
      if (BLK_FREE) begin free_cyc.push_back(cyc); free_log.push_back(int'(FREE_ADDR)); end
      if (BLK_RD)    acc_log.push_back(cyc);
      if (!m_busy) begin
        if (e_rd) begin
          m_busy = 1; m_pend = 0; m_blk = BLK_ADDR; m_k = 0;
          m_next = cyc + 2 + S + C; m_free_at = -1;
        end
      end else if (cyc == m_free_at) begin
        m_busy = 0;
      end else begin
`ifdef SCA_RD_ABORT_EN
        ab = ABORT;
`endif
        if (ab) m_free_at = cyc + 1;
        else if (e_strb) begin
          if (m_k == 15) m_free_at = cyc + 1;
          else begin
            m_k++;
            if (FIFO_AFULL) m_pend = 1;
            else m_next = cyc + P;
          end
        end else if (m_pend && !FIFO_AFULL) begin
          m_pend = 0;
          m_next = cyc + P;
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic accept_one(input logic [3:0] addr);
    BLK_ADDR = addr; BLK_VLD = 1'b1;
    t0 = cyc;
    tick();
    BLK_VLD = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; BLK_VLD = 1'b0; BLK_ADDR = 4'd0; FIFO_AFULL = 1'b0; ABORT = 1'b0;
    model_reset();
    tbl[0] = '{1'b0, 1'b0, 4'h5, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 4'h5, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 4'h5, 1'b0, 3'd0};
    tbl[3] = '{1'b1, 1'b0, 4'h5, 1'b1, 3'd1};

    // Reset state
    #1;
    repeat (2) tick();
    chk("reset_state", STATE, 3'd0);
    RST = 1'b0;
    clr_logs();

    // IDLE handshake table, last row accepts block 5
    for (int i = 0; i < 4; i++) begin
      BLK_VLD = tbl[i].vld; FIFO_AFULL = tbl[i].afull; BLK_ADDR = tbl[i].addr;
      t0 = cyc;
      #1;
      chk("tbl_blk_rd", BLK_RD, tbl[i].e_rd);
      tick();
      chk("tbl_state", STATE, tbl[i].e_state);
    end
    BLK_VLD = 1'b0;
    while (cyc < t0 + 133) tick();
    chk("blk5_strb_count", strb_log.size(), 16);
    for (int k = 0; k < 16; k++) chk("blk5_strb_cycle", qget(strb_log, k), t0 + 9 + 8 * k);
    chk("blk5_last_cycle", qget(last_log, 0), t0 + 129);
    chk("blk5_free_cycle", qget(free_cyc, 0), t0 + 130);
    chk("blk5_free_addr", qget(free_log, 0), 5);
    chk("blk5_conv_count", n_conv, 16);

    // Backpressure after sample 3 for 10 cycles
    clr_logs();
    accept_one(4'hC);
    while (cyc < t0 + 33) tick();
    FIFO_AFULL = 1'b1;
    repeat (10) tick();
    FIFO_AFULL = 1'b0;
    while (cyc < t0 + 145) tick();
    chk("afull_strb_count", strb_log.size(), 16);
    chk("afull_smp4_delay", qget(strb_log, 4) - qget(strb_log, 3), P + 10);
    chk("afull_conv_count", n_conv, 16);
    chk("afull_free_addr", qget(free_log, 0), 12);

    // Back-to-back blocks 2 then 3
    clr_logs();
    BLK_ADDR = 4'h2; BLK_VLD = 1'b1;
    tick();
    BLK_ADDR = 4'h3;
    for (int i = 0; i < 300 && acc_log.size() < 2; i++) tick();
    BLK_VLD = 1'b0;
    repeat (135) tick();
    chk("b2b_accepts", acc_log.size(), 2);
    chk("b2b_spacing", qget(acc_log, 1) - qget(acc_log, 0), 131);
    chk("b2b_free0", qget(free_log, 0), 2);
    chk("b2b_free1", qget(free_log, 1), 3);

    // Reset in the middle of a block
    clr_logs();
    accept_one(4'h9);
    while (cyc < t0 + 50) tick();
    RST = 1'b1;
    #1;
    chk("async_reset_outs", {BLK_RD, SCA_RADR, SCA_RDENA, ADC_CONV, DATA_STRB, LAST_SMP, BLK_FREE, FREE_ADDR, BUSY, STATE}, 0);
    tick();
    RST = 1'b0;
    repeat (20) tick();
    chk("rst_no_free", free_log.size(), 0);
    clr_logs();
    accept_one(4'hA);
    while (cyc < t0 + 133) tick();
    chk("rst_restart_strbs", strb_log.size(), 16);
    chk("rst_restart_first", qget(strb_log, 0), t0 + 9);

    // ABORT during sample 7 conversion
    clr_logs();
    accept_one(4'h7);
    while (cyc < t0 + 62) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    while (cyc < t0 + 140) tick();
`ifdef SCA_RD_ABORT_EN
    chk("abort_strb_count", strb_log.size(), 7);
    chk("abort_free_cycle", qget(free_cyc, 0), t0 + 63);
`else
    chk("abort_strb_count", strb_log.size(), 16);
    chk("abort_free_cycle", qget(free_cyc, 0), t0 + 130);
`endif
    chk("abort_free_addr", qget(free_log, 0), 7);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      BLK_VLD    = ($urandom_range(0, 3) != 0);
      BLK_ADDR   = 4'($urandom);
      FIFO_AFULL = ($urandom_range(0, 3) == 0);
      ABORT      = ($urandom_range(0, 99) < 2);
      tick();
    end
    BLK_VLD = 1'b0; FIFO_AFULL = 1'b0; ABORT = 1'b0;
    repeat (200) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
